// File: rtl/dm_sram_responder_pkg.sv
// Shared definitions for the SRAM responders: FSM state encoding and the
// idle (deasserted) bus levels, reused by the instruction-side Ram1 responder.
package dm_sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

  localparam int WAIT_W = 4;

  function automatic logic [WAIT_W-1:0] wait_load(input int wait_cycles);
    return WAIT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/dm_sram_responder_if.sv
// MEM-stage data-memory request/response bus between exe_mem and the responder.
interface dm_sram_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] Address;
  logic [15:0] WriteData;
  logic [15:0] ReadData;
  logic        mem_stall;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, mem_stall
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, mem_stall
  );
endinterface

// File: rtl/dm_sram_responder.sv
// Data-memory responder: runs one multi-cycle SRAM access per MEM-stage
// request and stalls the pipeline until the access has been strobed.
module dm_sram_responder
  import dm_sram_responder_pkg::*;
#(
  parameter int         WAIT_CYCLES = 1,
  parameter logic [1:0] ADDR_HI     = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst,
  dm_sram_responder_if.slave   mem,
  output logic [17:0]          ram_addr,
  output logic [15:0]          ram_dq_o,
  output logic                 ram_dq_oe,
  input  logic [15:0]          ram_dq_i,
  output logic                 ram_ce_n,
  output logic                 ram_oe_n,
  output logic                 ram_we_n
);

  localparam logic [WAIT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  mem_state_e        state_q, state_d;
  logic              op_wr_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [15:0]       read_data_q;
  logic              req;
  logic              stall;
  sram_ctl_t         ctl;

  assign req = mem.MemRead | mem.MemWrite;

  // Address/data/op are captured only on IDLE->SETUP so the SRAM sees a
  // stable address for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      ram_addr    <= '0;
      ram_dq_o    <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            op_wr_q  <= mem.MemWrite;
            ram_addr <= {ADDR_HI, mem.Address};
            ram_dq_o <= mem.WriteData;
          end
        end
        ST_SETUP: cnt_q <= CNT_LOAD;
        ST_STROBE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!op_wr_q) begin
            read_data_q <= ram_dq_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ctl     = SRAM_CTL_IDLE;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = req;
        if (req) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        stall    = 1'b1;
        ctl.ce_n = 1'b0;
        if (op_wr_q) ctl.dq_oe = 1'b1;
        else         ctl.oe_n  = 1'b0;
        state_d  = ST_STROBE;
      end
      ST_STROBE: begin
        stall    = 1'b1;
        ctl.ce_n = 1'b0;
        if (op_wr_q) begin
          ctl.we_n  = 1'b0;
          ctl.dq_oe = 1'b1;
        end else begin
          ctl.oe_n  = 1'b0;
        end
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Write keeps the chip selected and the bus driven for data hold.
        if (op_wr_q) begin
          ctl.ce_n  = 1'b0;
          ctl.dq_oe = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_ce_n      = ctl.ce_n;
  assign ram_oe_n      = ctl.oe_n;
  assign ram_we_n      = ctl.we_n;
  assign ram_dq_oe     = ctl.dq_oe;
  assign mem.ReadData  = read_data_q;
  assign mem.mem_stall = stall & ~rst;

endmodule
